// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_seq
//  Purpose  : Multi-cycle RV32 M-subset multiply/divide sequencer. Has no
//             adder of its own: it borrows the shared integer ALU one op per
//             cycle (ADD / SUB / SLTU) while alu_own is high.
//             Shift-add multiply (low 32 bits) and restoring division.
//  Options  : define MULDIV_SIGNED_EN to add signed DIV/REM support
//             (NEG_IN and FIX states); otherwise op 101/110 are illegal.
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_seq #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] opa,
   input  logic [XLEN-1:0] opb,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic            alu_own,
   output logic [3:0]      alu_op,
   output logic [XLEN-1:0] alu_a,
   output logic [XLEN-1:0] alu_b,
   input  logic [XLEN-1:0] alu_out
);

   localparam logic [2:0] OP_MUL  = 3'b000;
   localparam logic [2:0] OP_DIVU = 3'b001;
   localparam logic [2:0] OP_REMU = 3'b010;
`ifdef MULDIV_SIGNED_EN
   localparam logic [2:0] OP_DIV  = 3'b101;
   localparam logic [2:0] OP_REM  = 3'b110;
`endif

   localparam logic [3:0] ALU_NONE = 4'b0000;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLTU = 4'b0111;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
   localparam logic [XLEN-1:0]  ALL_ONES = {XLEN{1'b1}};

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_MUL_STEP = 3'd1,
      S_DIV_CMP  = 3'd2,
      S_DIV_SUB  = 3'd3,
      S_DONE     = 3'd4
`ifdef MULDIV_SIGNED_EN
      ,
      S_NEG_IN   = 3'd5,
      S_FIX      = 3'd6
`endif
   } state_t;

   state_t            state_q, state_d;
   logic [2:0]        op_q, op_d;
   logic [XLEN-1:0]   a_q, a_d;        // multiplicand / dividend
   logic [XLEN-1:0]   b_q, b_d;        // multiplier / divisor
   logic [XLEN-1:0]   acc_q, acc_d;
   logic [XLEN-1:0]   rem_q, rem_d;
   logic [XLEN-1:0]   quot_q, quot_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              ge_q, ge_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [XLEN-1:0]   result_q, result_d;
`ifdef MULDIV_SIGNED_EN
   logic              q_neg_q, q_neg_d;  // quotient must be negated
   logic              r_neg_q, r_neg_d;  // remainder must be negated
   logic [XLEN-1:0]   w_fix_val;
   logic              w_fix_neg;
`endif

   logic [XLEN-1:0]   w_shifted;
   logic              w_is_div;
   logic              w_is_quot;

   // Next partial remainder: shift in the next dividend bit, MSB first.
   assign w_shifted = {rem_q[XLEN-2:0], a_q[CNT_LAST - count_q]};

   // Classify the incoming request for divide-by-zero handling.
   always_comb begin
      w_is_div  = (op == OP_DIVU) || (op == OP_REMU);
      w_is_quot = (op == OP_DIVU);
`ifdef MULDIV_SIGNED_EN
      w_is_div  = w_is_div  || (op == OP_DIV) || (op == OP_REM);
      w_is_quot = w_is_quot || (op == OP_DIV);
`endif
   end

`ifdef MULDIV_SIGNED_EN
   // Value and sign rule applied in the FIX step.
   always_comb begin
      w_fix_val = (op_q == OP_REM) ? rem_q   : quot_q;
      w_fix_neg = (op_q == OP_REM) ? r_neg_q : q_neg_q;
   end
`endif

   // Next-state, datapath and ALU drive; ALU drive depends only on flops.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      rem_d    = rem_q;
      quot_d   = quot_q;
      count_d  = count_q;
      ge_d     = ge_q;
      result_d = result_q;
`ifdef MULDIV_SIGNED_EN
      q_neg_d  = q_neg_q;
      r_neg_d  = r_neg_q;
`endif
      alu_own  = 1'b0;
      alu_op   = ALU_NONE;
      alu_a    = '0;
      alu_b    = '0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d    = op;
               a_d     = opa;
               b_d     = opb;
               acc_d   = '0;
               rem_d   = '0;
               quot_d  = '0;
               count_d = '0;
               ge_d    = 1'b0;
               if (op == OP_MUL) begin
                  state_d = S_MUL_STEP;
               end else if (w_is_div && (opb == '0)) begin
                  state_d  = S_DONE;
                  result_d = w_is_quot ? ALL_ONES : opa;
               end else if ((op == OP_DIVU) || (op == OP_REMU)) begin
                  state_d = S_DIV_CMP;
`ifdef MULDIV_SIGNED_EN
               end else if ((op == OP_DIV) || (op == OP_REM)) begin
                  state_d = S_NEG_IN;
                  q_neg_d = opa[XLEN-1] ^ opb[XLEN-1];
                  r_neg_d = opa[XLEN-1];
`endif
               end else begin
                  state_d  = S_DONE;
                  result_d = '0;
               end
            end
         end

         S_MUL_STEP: begin
            if (b_q[0]) begin
               alu_own = 1'b1;
               alu_op  = ALU_ADD;
               alu_a   = acc_q;
               alu_b   = a_q;
               acc_d   = alu_out;
            end
            a_d     = {a_q[XLEN-2:0], 1'b0};
            b_d     = {1'b0, b_q[XLEN-1:1]};
            count_d = count_q + 1'b1;
            if (count_q == CNT_LAST) begin
               state_d  = S_DONE;
               result_d = acc_d;
            end
         end

         S_DIV_CMP: begin
            alu_own = 1'b1;
            alu_op  = ALU_SLTU;
            alu_a   = w_shifted;
            alu_b   = b_q;
            rem_d   = w_shifted;
            // A bit shifted out of rem means the true value exceeds divisor.
            ge_d    = rem_q[XLEN-1] | (alu_out == '0);
            state_d = S_DIV_SUB;
         end

         S_DIV_SUB: begin
            if (ge_q) begin
               // Modular subtraction is exact even when the carry bit was lost.
               alu_own = 1'b1;
               alu_op  = ALU_SUB;
               alu_a   = rem_q;
               alu_b   = b_q;
               rem_d   = alu_out;
            end
            quot_d = {quot_q[XLEN-2:0], ge_q};
            if (count_q == CNT_LAST) begin
`ifdef MULDIV_SIGNED_EN
               if ((op_q == OP_DIV) || (op_q == OP_REM)) begin
                  state_d = S_FIX;
               end else
`endif
               begin
                  state_d  = S_DONE;
                  result_d = (op_q == OP_REMU) ? rem_d : quot_d;
               end
            end else begin
               count_d = count_q + 1'b1;
               state_d = S_DIV_CMP;
            end
         end

`ifdef MULDIV_SIGNED_EN
         S_NEG_IN: begin
            // count 0 handles the dividend, count 1 the divisor.
            if (!count_q[0]) begin
               if (a_q[XLEN-1]) begin
                  alu_own = 1'b1;
                  alu_op  = ALU_SUB;
                  alu_a   = '0;
                  alu_b   = a_q;
                  a_d     = alu_out;
               end
               count_d = CNT_W'(1);
            end else begin
               if (b_q[XLEN-1]) begin
                  alu_own = 1'b1;
                  alu_op  = ALU_SUB;
                  alu_a   = '0;
                  alu_b   = b_q;
                  b_d     = alu_out;
               end
               count_d = '0;
               state_d = S_DIV_CMP;
            end
         end

         S_FIX: begin
            if (w_fix_neg) begin
               alu_own  = 1'b1;
               alu_op   = ALU_SUB;
               alu_a    = '0;
               alu_b    = w_fix_val;
               result_d = alu_out;
            end else begin
               result_d = w_fix_val;
            end
            state_d = S_DONE;
         end
`endif

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
      done_d = (state_d == S_DONE);
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         rem_q    <= '0;
         quot_q   <= '0;
         count_q  <= '0;
         ge_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
`ifdef MULDIV_SIGNED_EN
         q_neg_q  <= 1'b0;
         r_neg_q  <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         rem_q    <= rem_d;
         quot_q   <= quot_d;
         count_q  <= count_d;
         ge_q     <= ge_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
`ifdef MULDIV_SIGNED_EN
         q_neg_q  <= q_neg_d;
         r_neg_q  <= r_neg_d;
`endif
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;

endmodule
`default_nettype wire
